// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: two-requester pixel write arbiter in front of a
// single-port VRAM, with a full-screen colour fill after reset or on request.
// Optional feature: define VRAM_ARB_DEDUP_EN to skip rewriting a pixel that a
// requester has just written with the same colour.
module vram_write_arbiter #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int VRAM_W         = 16,
    parameter int ADDR_W         = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              clear_req,
    input  logic [VRAM_W-1:0] clear_color,
    input  logic              req0_valid,
    input  logic [8:0]        req0_x,
    input  logic [8:0]        req0_y,
    input  logic [VRAM_W-1:0] req0_color,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [8:0]        req1_x,
    input  logic [8:0]        req1_y,
    input  logic [VRAM_W-1:0] req1_color,
    output logic              req1_ready,
    output logic              wr_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [VRAM_W-1:0] wr_data,
    output logic              clearing,
    output logic              dropped
);

    localparam int                NPIX      = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [31:0]       DW        = 32'(DISPLAY_WIDTH);
    localparam logic [31:0]       DH        = 32'(DISPLAY_HEIGHT);

    typedef enum logic {
        S_CLEARING = 1'b0,
        S_ACTIVE   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [VRAM_W-1:0]   clr_color_q, clr_color_d;
    logic                rr_q, rr_d;        // 1: req1 wins a tie
    logic                wr_ena_q, wr_ena_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [VRAM_W-1:0]   wr_data_q, wr_data_d;
    logic                dropped_q, dropped_d;

    logic                gnt1;              // selected requester index
    logic                accept;
    logic [8:0]          sel_x, sel_y;
    logic [VRAM_W-1:0]   sel_color;
    logic [ADDR_W-1:0]   sel_addr;
    logic                in_range;
    logic                dup_hit;

    // Arbitration, pixel selection and address generation.
    always_comb begin
        gnt1      = req1_valid & (~req0_valid | rr_q);
        accept    = (state_q == S_ACTIVE) & ~clear_req & (req0_valid | req1_valid);
        sel_x     = gnt1 ? req1_x : req0_x;
        sel_y     = gnt1 ? req1_y : req0_y;
        sel_color = gnt1 ? req1_color : req0_color;
        in_range  = (32'(sel_x) < DW) && (32'(sel_y) < DH);
        sel_addr  = ADDR_W'(sel_y) * ADDR_W'(DISPLAY_WIDTH) + ADDR_W'(sel_x);
    end

    assign req0_ready = accept & ~gnt1;
    assign req1_ready = accept & gnt1;

`ifdef VRAM_ARB_DEDUP_EN
    logic [1:0]                   seen_vld_q, seen_vld_d;
    logic [1:0][ADDR_W-1:0]       seen_addr_q, seen_addr_d;
    logic [1:0][VRAM_W-1:0]       seen_color_q, seen_color_d;

    assign dup_hit = seen_vld_q[gnt1] && (seen_addr_q[gnt1] == sel_addr)
                     && (seen_color_q[gnt1] == sel_color);

    // Per-requester memory of the last pixel written; forgotten by any fill.
    always_comb begin
        seen_vld_d   = seen_vld_q;
        seen_addr_d  = seen_addr_q;
        seen_color_d = seen_color_q;
        if (state_q == S_CLEARING || clear_req) begin
            seen_vld_d = '0;
        end else if (accept && in_range && !dup_hit) begin
            seen_vld_d[gnt1]   = 1'b1;
            seen_addr_d[gnt1]  = sel_addr;
            seen_color_d[gnt1] = sel_color;
        end
    end

    // Dedup registers.
    // NOTE: only the valid bits need a reset; address/colour are ignored until valid.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            seen_vld_q <= '0;
        end else begin
            seen_vld_q <= seen_vld_d;
        end
    end

    // Stored address/colour, qualified by seen_vld_q.
    always_ff @(posedge clk) begin
        seen_addr_q  <= seen_addr_d;
        seen_color_q <= seen_color_d;
    end
`else
    assign dup_hit = 1'b0;
`endif

    // Next-state logic: fill sequencing, pixel acceptance and write generation.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_color_d = clr_color_q;
        rr_d        = rr_q;
        wr_ena_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        dropped_d   = 1'b0;
        case (state_q)
            S_CLEARING: begin
                wr_ena_d  = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = clr_color_q;
                if (cnt_q == '0) begin
                    state_d = S_ACTIVE;
                    cnt_d   = LAST_ADDR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (clear_req) begin
                    state_d     = S_CLEARING;
                    cnt_d       = LAST_ADDR;
                    clr_color_d = clear_color;
                end else if (accept) begin
                    rr_d = ~gnt1;
                    if (!in_range) begin
                        dropped_d = 1'b1;
                    end else if (!dup_hit) begin
                        wr_ena_d  = 1'b1;
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_color;
                    end
                end
            end
            default: state_d = S_CLEARING;
        endcase
    end

    // State and output registers; reset aborts any fill or write at once.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_CLEARING;
            cnt_q       <= LAST_ADDR;
            clr_color_q <= '0;
            rr_q        <= 1'b0;
            wr_ena_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_color_q <= clr_color_d;
            rr_q        <= rr_d;
            wr_ena_q    <= wr_ena_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            dropped_q   <= dropped_d;
        end
    end

    assign wr_ena   = wr_ena_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign dropped  = dropped_q;
    assign clearing = (state_q == S_CLEARING);

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Testbench for vram_write_arbiter: random and directed pixel traffic, with a
// queue-based scoreboard fed by a behavioural model of the arbiter's rules.
// The display height is shortened so each fill is 240*8 cycles.
module tb_vram_write_arbiter;

    localparam int W    = 240;
    localparam int H    = 8;
    localparam int VW   = 16;
    localparam int NPIX = W * H;
    localparam int AW   = $clog2(NPIX);

    logic          clk = 1'b0;
    logic          rstb;
    logic          clear_req;
    logic [VW-1:0] clear_color;
    logic          req0_valid, req1_valid;
    logic [8:0]    req0_x, req0_y, req1_x, req1_y;
    logic [VW-1:0] req0_color, req1_color;
    logic          req0_ready, req1_ready;
    logic          wr_ena;
    logic [AW-1:0] wr_addr;
    logic [VW-1:0] wr_data;
    logic          clearing;
    logic          dropped;

    always #5 clk = ~clk;

    vram_write_arbiter #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .VRAM_W        (VW),
        .ADDR_W        (AW)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .clear_req  (clear_req),
        .clear_color(clear_color),
        .req0_valid (req0_valid),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_color (req0_color),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_color (req1_color),
        .req1_ready (req1_ready),
        .wr_ena     (wr_ena),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clearing   (clearing),
        .dropped    (dropped)
    );

    typedef struct {
        bit is_drop;
        int addr;
        int data;
    } ev_t;

    typedef struct {
        bit v;
        int x;
        int y;
        int c;
    } pix_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Reference model state
    int  clear_left;
    int  last_gnt;
    bit  seen_v[2];
    int  seen_a[2];
    int  seen_c[2];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_write(input int a, input int d);
        ev_t e;
        e.is_drop = 1'b0;
        e.addr    = a;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic push_drop();
        ev_t e;
        e.is_drop = 1'b1;
        e.addr    = 0;
        e.data    = 0;
        exp_q.push_back(e);
    endtask

    task automatic model_start_fill(input int color);
        clear_left = NPIX;
        for (int a = NPIX - 1; a >= 0; a--) push_write(a, color);
        seen_v[0] = 1'b0;
        seen_v[1] = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_gnt = 1;
        model_start_fill(0);
    endtask

    task automatic model_accept(input int g, input pix_t p);
        int a;
        if (p.x >= W || p.y >= H) begin
            push_drop();
        end else begin
            a = p.y * W + p.x;
`ifdef VRAM_ARB_DEDUP_EN
            if (!(seen_v[g] && seen_a[g] == a && seen_c[g] == p.c)) begin
                push_write(a, p.c);
                seen_v[g] = 1'b1;
                seen_a[g] = a;
                seen_c[g] = p.c;
            end
`else
            push_write(a, p.c);
`endif
        end
    endtask

    // One clock cycle of stimulus; readiness and fill status checked mid-cycle.
    task automatic drive(input pix_t p0, input pix_t p1, input bit clr, input int cc);
        bit exp_r0, exp_r1;
        int g;
        req0_valid  = p0.v; req0_x = 9'(p0.x); req0_y = 9'(p0.y); req0_color = VW'(p0.c);
        req1_valid  = p1.v; req1_x = 9'(p1.x); req1_y = 9'(p1.y); req1_color = VW'(p1.c);
        clear_req   = clr;
        clear_color = VW'(cc);
        @(negedge clk);
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        check("clearing", clearing, clear_left > 0);
        if (clear_left > 0) begin
            clear_left--;
        end else if (clr) begin
            model_start_fill(cc);
        end else if (p0.v || p1.v) begin
            if (p0.v && p1.v) g = (last_gnt == 0) ? 1 : 0;
            else g = p1.v ? 1 : 0;
            last_gnt = g;
            if (g == 0) exp_r0 = 1'b1; else exp_r1 = 1'b1;
            model_accept(g, (g == 0) ? p0 : p1);
        end
        check("req0_ready", req0_ready, exp_r0);
        check("req1_ready", req1_ready, exp_r1);
        @(posedge clk);
        #1;
    endtask

    function automatic pix_t rnd_pix(input int valid_pct);
        pix_t p;
        p.v = ($urandom_range(0, 99) < valid_pct);
        p.x = $urandom_range(0, 260);
        p.y = $urandom_range(0, 10);
        p.c = ($urandom_range(0, 3) == 0) ? 16'hF800 : $urandom_range(0, 65535);
        return p;
    endfunction

    function automatic pix_t mk(input bit v, input int x, input int y, input int c);
        pix_t p;
        p.v = v; p.x = x; p.y = y; p.c = c;
        return p;
    endfunction

    task automatic idle_until_active();
        while (clear_left > 0) drive(rnd_pix(50), rnd_pix(50), 1'b0, 0);
    endtask

    // Monitor: every write or drop must match the head of the expected queue;
    // otherwise wr_addr/wr_data must hold the last expected write.
    int last_addr = 0;
    int last_data = 0;
    always @(negedge clk) begin
        ev_t e;
        if (rstb !== 1'b1) begin
            last_addr = 0;
            last_data = 0;
        end else begin
            check("ena_drop_exclusive", wr_ena & dropped, 0);
            if (wr_ena || dropped) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: wr_ena=%0b dropped=%0b addr=%0d, expected no output at %0t",
                             wr_ena, dropped, wr_addr, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("dropped", dropped, e.is_drop);
                    if (!e.is_drop) begin
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_data", wr_data, e.data);
                        last_addr = e.addr;
                        last_data = e.data;
                    end
                end
            end else begin
                check("hold_addr", wr_addr, last_addr);
                check("hold_data", wr_data, last_data);
            end
        end
    end

    initial begin
        pix_t none;
        none = mk(1'b0, 0, 0, 0);
        rstb = 1'b0;
        clear_req = 1'b0; clear_color = '0;
        req0_valid = 1'b1; req0_x = 9'd1; req0_y = 9'd1; req0_color = 16'h1234;
        req1_valid = 1'b1; req1_x = 9'd2; req1_y = 9'd1; req1_color = 16'h4321;
        clear_left = 0; last_gnt = 1;
        seen_v[0] = 1'b0; seen_v[1] = 1'b0;
        seen_a[0] = 0; seen_a[1] = 0; seen_c[0] = 0; seen_c[1] = 0;

        // Reset values
        @(negedge clk);
        check("rst_wr_ena", wr_ena, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_dropped", dropped, 0);
        check("rst_clearing", clearing, 1);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);

        // Start a fill, then abort it with reset mid-way
        @(posedge clk); #1;
        rstb = 1'b1;
        model_reset();
        repeat (60) drive(rnd_pix(50), rnd_pix(50), 1'b0, 0);
        #2 rstb = 1'b0;
        #1 check("abort_wr_ena", wr_ena, 0);
        check("abort_clearing", clearing, 1);
        @(posedge clk); #1;
        rstb = 1'b1;
        model_reset();
        idle_until_active();

        // Tie-break alternation from the reset pointer
        repeat (4) drive(mk(1'b1, 20, 1, 16'hAAAA), mk(1'b1, 21, 1, 16'h5555), 1'b0, 0);
        drive(none, none, 1'b0, 0);
        // Single write latency and address
        drive(mk(1'b1, 10, 2, 16'hFFFF), none, 1'b0, 0);
        drive(none, none, 1'b0, 0);
        // Out-of-range pixel
        drive(none, mk(1'b1, 240, 5, 16'h1111), 1'b0, 0);
        drive(none, none, 1'b0, 0);
        // Same pixel twice from one requester
        drive(mk(1'b1, 3, 3, 16'hF800), none, 1'b0, 0);
        drive(mk(1'b1, 3, 3, 16'hF800), none, 1'b0, 0);
        drive(none, none, 1'b0, 0);

        // Random traffic with occasional clears (ignored ones during fills too)
        for (int i = 0; i < 600; i++)
            drive(rnd_pix(70), rnd_pix(70), ($urandom_range(0, 299) == 0), $urandom_range(0, 65535));
        idle_until_active();

        // Clear colliding with a valid pixel, plus a second clear mid-fill
        drive(mk(1'b1, 5, 5, 16'h1234), none, 1'b1, 16'h001F);
        for (int i = 0; i < 100; i++) drive(rnd_pix(50), rnd_pix(50), 1'b0, 0);
        drive(rnd_pix(50), rnd_pix(50), 1'b1, 16'h07E0);
        idle_until_active();

        // Repeat pixel after the clear
        drive(mk(1'b1, 3, 3, 16'hF800), none, 1'b0, 0);
        drive(mk(1'b1, 3, 3, 16'hF800), none, 1'b0, 0);
        repeat (3) drive(none, none, 1'b0, 0);

        // Drain
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_write_arbiter.md
VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 Parameters SHALL be: DISPLAY_WIDTH, default 240, pixels per row; DISPLAY_HEIGHT, default 320, rows; VRAM_W, default 16, pixel width; ADDR_W, default $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT), VRAM address width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line:
 clk  in  1  sole clock, rising edge.
 rstb  in  1  asynchronous active-low reset.
 clear_req  in  1  single-cycle request to refill VRAM.
 clear_color  in  VRAM_W  fill colour, sampled when a clear starts.
 reqN_valid  in  1  requester N (N=0,1) has a pixel.
 reqN_x  in  9  column.
 reqN_y  in  9  row.
 reqN_color  in  VRAM_W  pixel colour.
 reqN_ready  out  1  pixel accepted this cycle.
 wr_ena  out  1  VRAM write strobe.
 wr_addr  out  ADDR_W  VRAM write address.
 wr_data  out  VRAM_W  VRAM write data.
 clearing  out  1  high while a fill is in progress.
 dropped  out  1  one-cycle pulse when an accepted pixel is discarded.

Function
REQ-004 The FSM SHALL have two states: S_CLEARING and S_ACTIVE.
REQ-005 In S_CLEARING, each cycle SHALL issue one write of the latched clear_color at the address held in a down-counter, then decrement the counter.
REQ-006 The counter SHALL be loaded with DISPLAY_WIDTH*DISPLAY_HEIGHT-1 on entry to S_CLEARING.
REQ-007 The FSM SHALL move to S_ACTIVE in the cycle after the write to address 0 has been issued.
REQ-008 A clear SHALL take exactly DISPLAY_WIDTH*DISPLAY_HEIGHT cycles.
REQ-009 Both reqN_ready outputs SHALL be 0 throughout S_CLEARING.
REQ-010 clear_req asserted in S_ACTIVE SHALL cause entry to S_CLEARING on the next edge.
REQ-011 clear_req asserted in S_CLEARING SHALL be ignored; the fill does not restart.
REQ-012 A clear_req that coincides with a pixel acceptance SHALL take priority: the pixel is not accepted and reqN_ready stays 0.
REQ-013 In S_ACTIVE, the grant SHALL go to the only valid requester; when both are valid, the grant SHALL go to the requester not granted most recently (round-robin).
REQ-014 The round-robin pointer SHALL update only on an acceptance.
REQ-015 reqN_ready SHALL be combinational: state==S_ACTIVE AND no clear_req AND reqN granted. At most one ready SHALL be high per cycle.
REQ-016 An accepted pixel SHALL appear on wr_ena/wr_addr/wr_data on the following cycle (latency 1).
REQ-017 wr_addr SHALL equal y*DISPLAY_WIDTH+x, computed at ADDR_W bits with no truncation for in-range coordinates.
REQ-018 A pixel with x>=DISPLAY_WIDTH or y>=DISPLAY_HEIGHT SHALL be accepted but not written (wr_ena=0), and dropped SHALL pulse 1 on the following cycle.
REQ-019 With no acceptance and not clearing, wr_ena SHALL be 0; wr_addr and wr_data hold their last values.
REQ-020 Sustained throughput SHALL be one pixel per cycle in S_ACTIVE.

Reset
REQ-021 While rstb=0: state=S_CLEARING, counter=DISPLAY_WIDTH*DISPLAY_HEIGHT-1, latched colour=0, wr_ena=0, wr_addr=0, wr_data=0, dropped=0, clearing=1, round-robin pointer favours req0.
REQ-022 After rstb deasserts, a full fill with colour 0 SHALL run.
REQ-023 Reset asserted mid-fill or mid-write SHALL abort immediately with no further write issued.

Configuration
REQ-024 When VRAM_ARB_DEDUP_EN is defined, each requester SHALL keep its last written address and colour.
REQ-025 With VRAM_ARB_DEDUP_EN defined, an accepted pixel matching that stored address and colour SHALL be accepted without a write and without a dropped pulse.
REQ-026 With VRAM_ARB_DEDUP_EN defined, the stored address and colour SHALL be invalidated on reset and on every clear.
REQ-027 When VRAM_ARB_DEDUP_EN is undefined, every in-range accepted pixel SHALL be written.

Verification
REQ-028 Release rstb -> wr_ena=1 for exactly 76800 cycles, addresses 76799 down to 0, data 0x0000; then clearing=0.
REQ-029 In S_ACTIVE, req0 at (10,2) colour 0xFFFF -> req0_ready=1, next cycle wr_addr=490, wr_data=0xFFFF.
REQ-030 Both requesters valid for 4 cycles -> grants alternate req0,req1,req0,req1.
REQ-031 req1 at (240,5) -> req1_ready=1, wr_ena=0, dropped pulses once.
REQ-032 clear_req with clear_color 0x001F while req0 is valid -> req0_ready=0, 76800 writes of 0x001F follow; a second clear_req mid-fill has no effect.
REQ-033 With VRAM_ARB_DEDUP_EN defined, req0 sends (3,3) 0xF800 twice -> one write; repeating after a clear -> one more write.
